// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared definitions for the stopwatch controller and the counter datapath it drives.
package stopwatch_lap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_PAUSED   = 2'b10,
    ST_LAP_VIEW = 2'b11
  } sw_state_t;

  localparam int DEF_TICK_DIV = 100_000_000;
  localparam int DEF_MIN_W    = 8;
  localparam int DEF_SEC_W    = 6;

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_fifo.sv
// Small lap-time FIFO with registered read data and a one-cycle valid strobe.
module lap_fifo
  import stopwatch_lap_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DEF_MIN_W + DEF_SEC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & ~empty & ~flush;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencer: button edge detect, run/pause/lap FSM, one-second prescaler
// and lap capture into a readout FIFO.
module stopwatch_lap_ctrl
  import stopwatch_lap_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int LAP_DEPTH = 4,
  parameter int MIN_W     = DEF_MIN_W,
  parameter int SEC_W     = DEF_SEC_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_btn,
  input  logic                         stop_btn,
  input  logic                         reset_btn,
  input  logic                         lap_btn,
  input  logic [MIN_W-1:0]             cur_min,
  input  logic [SEC_W-1:0]             cur_sec,
  output logic                         count_en,
  output logic                         clear_counters,
  output logic [1:0]                   status,
  output logic [MIN_W-1:0]             disp_min,
  output logic [SEC_W-1:0]             disp_sec,
  input  logic                         lap_rd_req,
  output logic                         lap_rd_valid,
  output logic [MIN_W-1:0]             lap_rd_min,
  output logic [SEC_W-1:0]             lap_rd_sec,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_overflow
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int LW = MIN_W + SEC_W;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  sw_state_t     state;
  sw_state_t     state_next;
  logic [PW-1:0] presc;
  logic          prev_start, prev_stop, prev_reset, prev_lap;
  logic          raw_start, raw_stop, raw_reset, raw_lap;
  logic          ev_start, ev_stop, ev_reset, ev_lap;
  logic          lap_push;
  logic          presc_clear;
  logic          counting;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] lap_rd_data;

  assign raw_start = start_btn & ~prev_start;
  assign raw_stop  = stop_btn  & ~prev_stop;
  assign raw_reset = reset_btn & ~prev_reset;
  assign raw_lap   = lap_btn   & ~prev_lap;

  // Only the highest-priority edge in a cycle survives; the rest are dropped.
  assign ev_reset = raw_reset;
  assign ev_stop  = raw_stop  & ~raw_reset;
  assign ev_start = raw_start & ~raw_stop & ~raw_reset;
  assign ev_lap   = raw_lap   & ~raw_start & ~raw_stop & ~raw_reset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    lap_push    = 1'b0;
    presc_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ev_start) begin
          state_next  = ST_RUNNING;
          presc_clear = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (ev_stop) begin
          state_next = ST_PAUSED;
        end else if (ev_lap) begin
          state_next = ST_LAP_VIEW;
          lap_push   = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (ev_start) begin
          state_next = ST_RUNNING;
        end
      end
      ST_LAP_VIEW: begin
        if (ev_stop) begin
          state_next = ST_PAUSED;
        end else if (ev_start) begin
          state_next = ST_RUNNING;
        end else if (ev_lap) begin
          lap_push = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (ev_reset) begin
      state_next  = ST_IDLE;
      presc_clear = 1'b1;
    end
  end

  // The prescaler advances only while staying in a counting state, so the cycle
  // that pauses or resumes does not consume part of the second.
  assign counting = ((state == ST_RUNNING) || (state == ST_LAP_VIEW)) &&
                    ((state_next == ST_RUNNING) || (state_next == ST_LAP_VIEW));

  assign status = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_start     <= 1'b0;
      prev_stop      <= 1'b0;
      prev_reset     <= 1'b0;
      prev_lap       <= 1'b0;
      presc          <= '0;
      count_en       <= 1'b0;
      clear_counters <= 1'b0;
      disp_min       <= '0;
      disp_sec       <= '0;
      lap_overflow   <= 1'b0;
    end else begin
      prev_start     <= start_btn;
      prev_stop      <= stop_btn;
      prev_reset     <= reset_btn;
      prev_lap       <= lap_btn;
      clear_counters <= ev_reset;
      count_en       <= counting && (presc == PRESC_MAX);
      if (presc_clear) begin
        presc <= '0;
      end else if (counting) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + PRESC_ONE;
      end
      // In lap view the display register doubles as the frozen lap latch.
      if ((state_next != ST_LAP_VIEW) || lap_push) begin
        disp_min <= cur_min;
        disp_sec <= cur_sec;
      end
      if (ev_reset) begin
        lap_overflow <= 1'b0;
      end else if (lap_push && fifo_full && !(lap_rd_req && !fifo_empty)) begin
        lap_overflow <= 1'b1;
      end
    end
  end

  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .WIDTH (LW)
  ) u_lap_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (ev_reset),
    .push     (lap_push),
    .pop      (lap_rd_req),
    .wr_data  ({cur_min, cur_sec}),
    .rd_valid (lap_rd_valid),
    .rd_data  (lap_rd_data),
    .count    (lap_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {lap_rd_min, lap_rd_sec} = lap_rd_data;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed plus randomized bench for stopwatch_lap_ctrl against a queue-based reference model,
// with lap readouts checked by a separate scoreboard monitor.
module tb_stopwatch_lap_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 4;
  localparam int MIN_W     = 8;
  localparam int SEC_W     = 6;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;

  localparam int EV_NONE  = 0;
  localparam int EV_LAP   = 1;
  localparam int EV_START = 2;
  localparam int EV_STOP  = 3;
  localparam int EV_RESET = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_btn, stop_btn, reset_btn, lap_btn;
  logic [MIN_W-1:0] cur_min;
  logic [SEC_W-1:0] cur_sec;
  logic             count_en, clear_counters;
  logic [1:0]       status;
  logic [MIN_W-1:0] disp_min;
  logic [SEC_W-1:0] disp_sec;
  logic             lap_rd_req, lap_rd_valid;
  logic [MIN_W-1:0] lap_rd_min;
  logic [SEC_W-1:0] lap_rd_sec;
  logic [2:0]       lap_count;
  logic             lap_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int ticks;

  // Reference model state
  int                     m_state;
  int                     m_presc;
  logic [3:0]             m_prev;
  logic [MIN_W+SEC_W-1:0] m_q[$];
  logic [MIN_W+SEC_W-1:0] exp_q[$];
  logic                   m_ovf, m_count_en, m_clear, m_valid;
  logic [MIN_W+SEC_W-1:0] m_disp;

  stopwatch_lap_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .LAP_DEPTH (LAP_DEPTH),
    .MIN_W     (MIN_W),
    .SEC_W     (SEC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_btn      (start_btn),
    .stop_btn       (stop_btn),
    .reset_btn      (reset_btn),
    .lap_btn        (lap_btn),
    .cur_min        (cur_min),
    .cur_sec        (cur_sec),
    .count_en       (count_en),
    .clear_counters (clear_counters),
    .status         (status),
    .disp_min       (disp_min),
    .disp_sec       (disp_sec),
    .lap_rd_req     (lap_rd_req),
    .lap_rd_valid   (lap_rd_valid),
    .lap_rd_min     (lap_rd_min),
    .lap_rd_sec     (lap_rd_sec),
    .lap_count      (lap_count),
    .lap_overflow   (lap_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts the effect of the current inputs at the coming clock edge.
  task automatic modelStep();
    int  evt;
    int  nxt;
    bit  push;
    bit  cnt;
    if (rst) begin
      m_state = S_IDLE; m_presc = 0; m_prev = '0; m_q.delete();
      m_ovf = 0; m_count_en = 0; m_clear = 0; m_valid = 0; m_disp = '0;
      return;
    end
    evt = EV_NONE;
    if (reset_btn && !m_prev[2])      evt = EV_RESET;
    else if (stop_btn && !m_prev[1])  evt = EV_STOP;
    else if (start_btn && !m_prev[0]) evt = EV_START;
    else if (lap_btn && !m_prev[3])   evt = EV_LAP;
    nxt  = m_state;
    push = 0;
    case (m_state)
      S_IDLE:  if (evt == EV_START) nxt = S_RUN;
      S_RUN:   if (evt == EV_STOP) nxt = S_PAUSE;
               else if (evt == EV_LAP) begin nxt = S_LAP; push = 1; end
      S_PAUSE: if (evt == EV_START) nxt = S_RUN;
      default: if (evt == EV_STOP) nxt = S_PAUSE;
               else if (evt == EV_START) nxt = S_RUN;
               else if (evt == EV_LAP) push = 1;
    endcase
    if (evt == EV_RESET) nxt = S_IDLE;
    cnt = (m_state == S_RUN || m_state == S_LAP) && (nxt == S_RUN || nxt == S_LAP);
    m_count_en = cnt && (m_presc == TICK_DIV - 1);
    if (evt == EV_RESET || (m_state == S_IDLE && nxt == S_RUN)) m_presc = 0;
    else if (cnt) m_presc = (m_presc + 1) % TICK_DIV;
    m_clear = (evt == EV_RESET);
    m_valid = 0;
    if (evt == EV_RESET) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      if (lap_rd_req && m_q.size() > 0) begin
        exp_q.push_back(m_q.pop_front());
        m_valid = 1;
      end
      if (push) begin
        if (m_q.size() < LAP_DEPTH) m_q.push_back({cur_min, cur_sec});
        else m_ovf = 1;
      end
    end
    if (nxt != S_LAP || push) m_disp = {cur_min, cur_sec};
    m_prev  = {lap_btn, reset_btn, stop_btn, start_btn};
    m_state = nxt;
  endtask

  // Called just after a rising edge: model the inputs, advance one cycle, compare.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("status", status, m_state);
    checkOutput("count_en", count_en, m_count_en);
    checkOutput("clear_counters", clear_counters, m_clear);
    checkOutput("disp", {disp_min, disp_sec}, m_disp);
    checkOutput("lap_rd_valid", lap_rd_valid, m_valid);
    checkOutput("lap_count", lap_count, m_q.size());
    checkOutput("lap_overflow", lap_overflow, m_ovf);
  endtask

  // Scoreboard monitor: every presented lap readout must match the oldest expected entry.
  always @(negedge clk) begin
    if (lap_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("lap_unexpected", 1, 0);
      end else begin
        checkOutput("lap_rd_data", {lap_rd_min, lap_rd_sec}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    start_btn = 0; stop_btn = 0; reset_btn = 0; lap_btn = 0; lap_rd_req = 0;
    cur_min = '0; cur_sec = '0;
    @(posedge clk);
    #1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_status", status, S_IDLE);
    rst = 1'b0;

    // First ticks after start from idle
    start_btn = 1; applyStimulus(); start_btn = 0;
    checkOutput("start_status", status, S_RUN);
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus();
      if (count_en) begin
        ticks++;
        checkOutput("tick_phase", i % 4, 0);
      end
    end
    checkOutput("tick_total", ticks, 3);

    // Pause keeps the partial second
    repeat (6) applyStimulus();
    stop_btn = 1; applyStimulus(); stop_btn = 0;
    checkOutput("stop_status", status, S_PAUSE);
    ticks = 0;
    repeat (10) begin applyStimulus(); ticks += int'(count_en); end
    checkOutput("paused_ticks", ticks, 0);
    start_btn = 1; applyStimulus(); start_btn = 0;
    applyStimulus(); checkOutput("resume_early", count_en, 0);
    applyStimulus(); checkOutput("resume_tick", count_en, 1);

    // Lap freezes the display
    cur_min = 3; cur_sec = 15; lap_btn = 1; applyStimulus(); lap_btn = 0;
    checkOutput("lap_status", status, S_LAP);
    cur_sec = 16; applyStimulus();
    cur_sec = 17; applyStimulus();
    checkOutput("lap_frozen", {disp_min, disp_sec}, {8'd3, 6'd15});
    start_btn = 1; applyStimulus(); start_btn = 0;
    checkOutput("unfreeze_status", status, S_RUN);
    cur_sec = 18; applyStimulus();
    checkOutput("unfreeze_disp", {disp_min, disp_sec}, {8'd3, 6'd18});

    // Reset event, then fill past capacity and drain
    reset_btn = 1; applyStimulus(); reset_btn = 0;
    checkOutput("rstevt_clear", clear_counters, 1);
    applyStimulus();
    checkOutput("clear_one_cycle", clear_counters, 0);
    checkOutput("rstevt_count", lap_count, 0);
    start_btn = 1; applyStimulus(); start_btn = 0;
    for (int k = 1; k <= 5; k++) begin
      cur_min = 0; cur_sec = 6'(k);
      lap_btn = 1; applyStimulus(); lap_btn = 0; applyStimulus();
    end
    checkOutput("full_count", lap_count, 4);
    checkOutput("overflow_set", lap_overflow, 1);
    lap_rd_req = 1; repeat (4) applyStimulus(); lap_rd_req = 0;
    applyStimulus();
    checkOutput("drained", lap_count, 0);
    lap_rd_req = 1; applyStimulus(); lap_rd_req = 0;
    checkOutput("empty_read", lap_rd_valid, 0);
    applyStimulus();

    // Simultaneous buttons
    start_btn = 1; applyStimulus(); start_btn = 0; applyStimulus();
    start_btn = 1; stop_btn = 1; lap_btn = 1; applyStimulus();
    start_btn = 0; stop_btn = 0; lap_btn = 0;
    checkOutput("multi_status", status, S_PAUSE);
    checkOutput("multi_nopush", lap_count, 0);
    applyStimulus();
    reset_btn = 1; start_btn = 1; applyStimulus(); reset_btn = 0; start_btn = 0;
    checkOutput("rst_start_status", status, S_IDLE);
    checkOutput("rst_start_clear", clear_counters, 1);
    checkOutput("overflow_cleared", lap_overflow, 0);
    applyStimulus();

    // Held start, then hard reset with entries pending
    start_btn = 1; repeat (20) applyStimulus(); start_btn = 0;
    checkOutput("held_status", status, S_RUN);
    cur_min = 7; cur_sec = 30; lap_btn = 1; applyStimulus(); lap_btn = 0; applyStimulus();
    cur_sec = 31; lap_btn = 1; applyStimulus(); lap_btn = 0; applyStimulus();
    checkOutput("pre_rst_count", lap_count, 2);
    rst = 1; applyStimulus(); rst = 0;
    checkOutput("rst_outputs", {status, count_en, clear_counters, disp_min, disp_sec,
                                lap_rd_valid, lap_count, lap_overflow}, 0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)  start_btn = ~start_btn;
      if ($urandom_range(0, 11) == 0) stop_btn  = ~stop_btn;
      if ($urandom_range(0, 3) == 0)  lap_btn   = ~lap_btn;
      if ($urandom_range(0, 39) == 0) reset_btn = ~reset_btn;
      lap_rd_req = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      cur_min    = MIN_W'($urandom_range(0, 255));
      cur_sec    = SEC_W'($urandom_range(0, 59));
      applyStimulus();
    end

    rst = 0; start_btn = 0; stop_btn = 0; lap_btn = 0; reset_btn = 0; lap_rd_req = 0;
    repeat (3) applyStimulus();
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
- Sequencing controller for the stopwatch counter datapath (seconds/minutes counters).
- Edge-detects the user buttons and runs the run/pause/lap state machine.
- Generates the prescaled count-enable tick and clear pulse that drive the counters.
- Captures lap times into a small FIFO read by a display/readout agent over a request/valid handshake.

Parameters:
TICK_DIV, 100000000, clk cycles per counted second (min 2)
LAP_DEPTH, 4, lap FIFO entries (power of 2)
MIN_W, 8, minutes width
SEC_W, 6, seconds width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start_btn  in  1  start level (already synchronised)
stop_btn  in  1  stop level
reset_btn  in  1  clear level
lap_btn  in  1  lap capture level
cur_min  in  MIN_W  minutes from counter datapath
cur_sec  in  SEC_W  seconds from counter datapath
count_en  out  1  one-cycle tick to seconds counter
clear_counters  out  1  one-cycle clear to counters
status  out  2  FSM state
disp_min  out  MIN_W  display minutes
disp_sec  out  SEC_W  display seconds
lap_rd_req  in  1  pop request
lap_rd_valid  out  1  lap data valid (one cycle)
lap_rd_min  out  MIN_W  popped lap minutes
lap_rd_sec  out  SEC_W  popped lap seconds
lap_count  out  clog2(LAP_DEPTH)+1  FIFO occupancy
lap_overflow  out  1  sticky: lap dropped on full FIFO

Behaviour:
- Reset (rst=1 at a clk edge): status=IDLE; prescaler=0; FIFO empty; all outputs 0; button history regs=0. rst overrides all other inputs.
- Each button acts on its rising edge only: previous level registered, event = btn & ~prev. Holding a button produces one event.
- Simultaneous events: priority is reset > stop > start > lap; lower-priority events in the same cycle are discarded.
- States: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10, LAP_VIEW=2'b11.
- IDLE: start -> RUNNING with prescaler cleared to 0. Stop and lap are ignored.
- RUNNING: stop -> PAUSED. Lap -> LAP_VIEW, pushes {cur_min,cur_sec}, latches the frozen display.
- LAP_VIEW (counting continues): lap pushes a new entry, updates the frozen display, stays in LAP_VIEW. Start -> RUNNING (display unfreezes). Stop -> PAUSED.
- PAUSED: start -> RUNNING with prescaler retained, so the partial second resumes. Lap is ignored.
- Reset event in any state:
  - -> IDLE.
  - clear_counters=1 for exactly one cycle (registered, the cycle after the event).
  - FIFO flushed; lap_overflow cleared; prescaler=0.
- Prescaler:
  - Increments only in RUNNING/LAP_VIEW.
  - At value TICK_DIV-1 it wraps to 0 and count_en=1 that cycle (registered output).
  - count_en never asserts in IDLE/PAUSED.
  - First tick comes TICK_DIV cycles after entering RUNNING from IDLE.
- Display: disp_* = cur_* registered (1-cycle latency) except in LAP_VIEW, where disp_* holds the latched lap value.
- Lap capture samples cur_* in the event cycle. If count_en is high that cycle, the pre-increment value is captured.
- FIFO:
  - Push when full: entry dropped, lap_overflow<=1 (sticky until reset event or rst).
  - lap_rd_req while non-empty: the next cycle lap_rd_valid=1 with the oldest entry, and occupancy decrements.
  - lap_rd_req while empty is ignored (valid stays 0).
  - Push and pop in the same cycle: both performed, count unchanged. When full, the push succeeds and no overflow is flagged.
  - Reset event and pop in the same cycle: flush wins, no valid.
- Pointer wrap: read/write pointers wrap modulo LAP_DEPTH. Occupancy is tracked by lap_count (0..LAP_DEPTH).

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE/ST_RUNNING/ST_PAUSED/ST_LAP_VIEW;
  - default TICK_DIV and widths MIN_W/SEC_W for reuse with the counters.
- One sub-module: lap_fifo (parameterised depth/width, sync rst, push/pop, count, full/empty, registered read data + valid).
- Edge detect, prescaler and FSM stay in the top.

Test Plan (TICK_DIV=4, LAP_DEPTH=4):
- Start pulse from IDLE -> status=01; count_en pulses at cycles 4, 8, 12 after the transition; none before cycle 4.
- Run 6 cycles, stop, wait 10, start -> no count_en while PAUSED; next count_en 2 cycles after resume, because the prescaler kept 2.
- RUNNING with cur=03:15, lap -> status=11, disp=03:15 while cur advances to 03:17. Start -> status=01 and disp tracks cur within 1 cycle.
- 5 lap events at cur 00:01..00:05 in LAP_VIEW -> lap_count=4, lap_overflow=1. Four rd_reqs -> valid data 00:01,00:02,00:03,00:04, then count=0. A fifth req gives no valid.
- Start, stop, lap asserted in the same cycle while RUNNING -> PAUSED only, no push. Reset plus any other button -> IDLE, clear_counters high exactly 1 cycle, FIFO empty, overflow 0.
- Hold start high 20 cycles from IDLE -> single transition. Assert rst mid-RUNNING with FIFO count 2 -> all outputs 0, status=00 on the next edge.
